// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op and state encodings for the multiply/divide unit
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // op[0]==0 selects the signed variants
    function automatic logic op_is_signed(input logic [1:0] op);
        return !op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - 2W-bit accumulator doing one shift-add or shift-subtract step per cycle
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] acc_next_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               div_q, div_d;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH-1:0] div_next;

    // One iteration: multiply adds b into the upper half when the low bit is set then shifts
    // right; divide shifts the next dividend bit into the remainder and restores on borrow.
    // The comparison (rather than the borrow bit) keeps a zero divisor well defined.
    always_comb begin
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        mul_next   = {mul_sum, acc_q[WIDTH-1:1]};
        rem_sh     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff       = rem_sh - {1'b0, b_q};
        div_ge     = (rem_sh >= {1'b0, b_q});
        rem_new    = div_ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        div_next   = {rem_new, acc_q[WIDTH-2:0], div_ge};
        acc_next_o = div_q ? div_next : mul_next;
    end

    // Load selects operands and mode; otherwise advance one step while enabled
    always_comb begin
        acc_d = acc_q;
        b_d   = b_q;
        div_d = div_q;
        if (load_i) begin
            acc_d = {{WIDTH{1'b0}}, a_i};
            b_d   = b_i;
            div_d = div_i;
        end else if (step_i) begin
            acc_d = acc_next_o;
        end
    end

    // Accumulator and operand registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with cancel and hi/lo result registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               div_q, neg_q, rem_neg_q, bzero_q;
    logic [WIDTH-1:0]   srca_q;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic               accept;
    logic               last;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    assign accept = start && !cancel && (state_q == S_IDLE || state_q == S_DONE);
    assign last   = (state_q == S_CALC) && (cnt_q == '0) && !cancel;

    // Signed ops iterate on magnitudes; the most-negative value maps onto its own unsigned magnitude
    always_comb begin
        sign_a = op_is_signed(op) && srca[WIDTH-1];
        sign_b = op_is_signed(op) && srcb[WIDTH-1];
        a_mag  = sign_a ? (~srca + 1'b1) : srca;
        b_mag  = sign_b ? (~srcb + 1'b1) : srcb;
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .step_i     (state_q == S_CALC),
        .div_i      (op_is_div(op)),
        .a_i        (a_mag),
        .b_i        (b_mag),
        .acc_next_o (acc_next)
    );

    // Next state and counter; cancel overrides everything and returns to IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (cancel) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_CALC;
                        cnt_d   = CNT_LAST;
                    end
                end
                S_CALC: begin
                    if (cnt_q == '0) state_d = S_DONE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                S_DONE: begin
                    if (start) begin
                        state_d = S_CALC;
                        cnt_d   = CNT_LAST;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Sign fix-up of the final step and hi/lo capture, only on the transition into DONE
    always_comb begin
        prod = neg_q ? (~acc_next + 1'b1) : acc_next;
        quo  = neg_q ? (~acc_next[WIDTH-1:0] + 1'b1) : acc_next[WIDTH-1:0];
        rem  = rem_neg_q ? (~acc_next[2*WIDTH-1:WIDTH] + 1'b1) : acc_next[2*WIDTH-1:WIDTH];
        hi_d = hi_q;
        lo_d = lo_q;
        if (last) begin
            if (!div_q) begin
                hi_d = prod[2*WIDTH-1:WIDTH];
                lo_d = prod[WIDTH-1:0];
            end else if (bzero_q) begin
                hi_d = srca_q;
                lo_d = '1;
            end else begin
                hi_d = rem;
                lo_d = quo;
            end
        end
    end

    // FSM state, latched operation attributes and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            bzero_q   <= 1'b0;
            srca_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (accept) begin
                div_q     <= op_is_div(op);
                neg_q     <= sign_a ^ sign_b;
                rem_neg_q <= sign_a;
                bzero_q   <= (srcb == '0);
                srca_q    <= srca;
            end
        end
    end

    assign busy = (state_q == S_CALC);
    assign done = (state_q == S_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
